// File: rtl/debounce.sv
// Synchronizer chain plus stable-count debouncer for a raw asynchronous level input.
// Optional DEBOUNCE_GLITCH_CNT_EN adds a saturating count of rejected candidate transitions.
module debounce #(
  parameter int   SYNC_STAGES = 2,
  parameter int   DEB_CYCLES  = 16,
  parameter logic INIT        = 1'b0,
  parameter int   GCNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  output logic              q,
  output logic              busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GCNT_W-1:0] glitch_cnt
`endif
);

  localparam int             CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam bit             DEB_ONE  = (DEB_CYCLES == 1);

  typedef enum logic {
    STABLE = 1'b0,
    PEND   = 1'b1
  } state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic                    q_n;
  logic [SYNC_STAGES-1:0]  sync;
  logic                    s;

  // Every synchronizer flop is reset so a reset reloads INIT through the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {SYNC_STAGES{INIT}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};
    end
  end

  assign s = sync[SYNC_STAGES-1];

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic glitch;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    q_n     = q;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    glitch  = 1'b0;
`endif
    unique case (state)
      STABLE: begin
        cnt_n = '0;
        if (s != q) begin
          if (DEB_ONE) begin
            q_n = s;
          end else begin
            cnt_n   = CNT_ONE;
            state_n = PEND;
          end
        end
      end
      PEND: begin
        if (s == q) begin
          // Candidate fell back before it was held long enough: reject it.
          cnt_n   = '0;
          state_n = STABLE;
`ifdef DEBOUNCE_GLITCH_CNT_EN
          glitch  = 1'b1;
`endif
        end else if (cnt == CNT_LAST) begin
          q_n     = s;
          cnt_n   = '0;
          state_n = STABLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = STABLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE;
      cnt   <= '0;
      q     <= INIT;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      q     <= q_n;
    end
  end

  // busy decodes the state register directly, so it has no path from in.
  assign busy = (state == PEND);

`ifdef DEBOUNCE_GLITCH_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if (glitch && (glitch_cnt != {GCNT_W{1'b1}})) begin
      glitch_cnt <= glitch_cnt + GCNT_W'(1);
    end
  end
`endif

endmodule
